uart_rx_os16: RTL

Standalone 16x-oversampling UART receiver: the far-end consumer of the frames produced by our UART transmitter. It recovers start/data/parity/stop from a serial line in its own clock domain and presents each byte on a parallel port held under a valid/ack handshake. It adds parity, framing and overrun status, and optional break detection. It sits behind the loopback or pad input and in front of a host register or FIFO.

---
 rtl/uart_rx_os16.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_os16.sv
// 16x-oversampled UART receiver; data_valid rises 1 cycle after the stop-bit mid-sample and is held until data_ack.
// A frame completing while data_valid is high is dropped and flagged as overrun. Break detection is enabled by UART_RX_BREAK_EN.
module uart_rx_os16 #(
  parameter int RX_SYS_CLK = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rx_clk,
  input  logic                  rst,
  input  logic                  rx_en,
  input  logic                  parity_en,
  input  logic                  odd_r_even_parity,
  input  logic                  rx,
  input  logic                  data_ack,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  overrun_error,
  output logic                  break_detect
);
  localparam int TICK_DIV = RX_SYS_CLK / (BAUD_RATE * 16);
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                  rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [2:0]            state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [3:0]            tidx_q, tidx_d;
  logic [1:0]            smp_q, smp_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bcnt_q, bcnt_d;
  logic                  par_en_q, par_en_d, par_even_q, par_even_d, par_bit_q, par_bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                  ovr_q, ovr_d, brk_q, brk_d;

  logic tick, maj, fall, commit, is_break, ack_fire, exp_par, mid, last;

  always_comb begin
    rx_s1_d    = rx;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    state_d    = state_q;
    div_d      = div_q;
    tidx_d     = tidx_q;
    smp_d      = smp_q;
    shift_d    = shift_q;
    bcnt_d     = bcnt_q;
    par_en_d   = par_en_q;
    par_even_d = par_even_q;
    par_bit_d  = par_bit_q;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;
    brk_d      = brk_q;
    commit     = 1'b0;

    tick     = (div_q == DIV_LAST);
    mid      = tick && (tidx_q == 4'd9);
    last     = tick && (tidx_q == 4'd15);
    maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s2_q) | (smp_q[1] & rx_s2_q);
    fall     = rx_prev_q & ~rx_s2_q;
    exp_par  = par_even_q ? (^shift_q) : ~(^shift_q);
    is_break = (shift_q == '0) && (!par_en_q || !par_bit_q) && !maj;

    if (state_q == S_IDLE) begin
      div_d  = '0;
      tidx_d = 4'd0;
    end else if (tick) begin
      div_d  = '0;
      tidx_d = tidx_q + 4'd1;
      if (tidx_q == 4'd7) smp_d[0] = rx_s2_q;
      if (tidx_q == 4'd8) smp_d[1] = rx_s2_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        // An unresolved break keeps the line from being read as a new start.
        if (rx_en && fall && !brk_q) begin
          state_d    = S_START;
          par_en_d   = parity_en;
          par_even_d = odd_r_even_parity;
        end
      end
      S_START: begin
        if (mid && maj) state_d = S_IDLE;
        else if (last) begin
          state_d = S_DATA;
          bcnt_d  = '0;
        end
      end
      S_DATA: begin
        if (mid) begin
          shift_d = shift_q >> 1;
          shift_d[DATA_WIDTH-1] = maj;
        end
        if (last) begin
          if (bcnt_q == BIT_LAST) state_d = par_en_q ? S_PARITY : S_STOP;
          else bcnt_d = bcnt_q + BIT_W'(1);
        end
      end
      S_PARITY: begin
        if (mid) par_bit_d = maj;
        if (last) state_d = S_STOP;
      end
      S_STOP: begin
        if (mid) begin
          state_d = S_IDLE;
`ifdef UART_RX_BREAK_EN
          if (is_break) brk_d = rx_en;
          else commit = rx_en;
`else
          commit = rx_en;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!rx_en) state_d = S_IDLE;
`ifdef UART_RX_BREAK_EN
    if (brk_q && rx_s2_q) brk_d = 1'b0;
`else
    brk_d = 1'b0;
`endif

    ack_fire = data_ack & valid_q;
    if (commit) begin
      if (!valid_q || ack_fire) begin
        data_d  = shift_q;
        perr_d  = par_en_q & (par_bit_q != exp_par);
        ferr_d  = ~maj;
        valid_d = 1'b1;
        ovr_d   = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (ack_fire) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (!rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= S_IDLE;
      div_q      <= '0;
      tidx_q     <= 4'd0;
      smp_q      <= 2'b00;
      shift_q    <= '0;
      bcnt_q     <= '0;
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
      par_bit_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      state_q    <= state_d;
      div_q      <= div_d;
      tidx_q     <= tidx_d;
      smp_q      <= smp_d;
      shift_q    <= shift_d;
      bcnt_q     <= bcnt_d;
      par_en_q   <= par_en_d;
      par_even_q <= par_even_d;
      par_bit_q  <= par_bit_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
      brk_q      <= brk_d;
    end
  end

  assign data_out      = data_q;
  assign data_valid    = valid_q;
  assign busy          = (state_q != S_IDLE);
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign overrun_error = ovr_q;
  assign break_detect  = brk_q;
endmodule
